// File: rtl/gat_pkg.sv
// Shared state encoding and default feature-memory geometry for the GAT layer scheduler.
package gat_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOAD = 3'd1,
        KICK      = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        READBACK  = 3'd5,
        FINISH    = 3'd6
    } gat_state_e;

    localparam int GAT_FEAT_DEPTH = 43328;
    localparam int GAT_FEAT_WIDTH = 32;

endpackage

// File: rtl/gat_rd_fifo.sv
// Small register-based FIFO that buffers feature words between the BRAM read pipeline
// and the result stream; read data is presented combinationally from the head entry.
module gat_rd_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 33
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign push_s = wr_en && (count_r != CW'(DEPTH));
    assign pop_s  = rd_en && (count_r != {CW{1'b0}});

    // Storage array; contents are don't-care while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign empty   = (count_r == {CW{1'b0}});

endmodule

// File: rtl/gat_layer_scheduler.sv
// Sequences GAT layers on the core, then streams the final feature memory out.
// Optional per-phase watchdog enabled by defining GAT_SCHED_TIMEOUT_EN.
module gat_layer_scheduler
    import gat_pkg::*;
#(
    parameter int NUM_LAYERS        = 2,
    parameter int NEW_FEATURE_DEPTH = GAT_FEAT_DEPTH,
    parameter int NEW_FEATURE_WIDTH = GAT_FEAT_WIDTH,
    parameter int RD_LAT            = 2,
    parameter int TIMEOUT_CYCLES    = 2**24
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 h_data_load_done,
    input  logic                                 h_node_info_load_done,
    input  logic                                 wgt_load_done,
    input  logic                                 gat_ready,
    output logic                                 gat_layer,
    output logic                                 core_start,
    output logic                                 load_req,
    output logic [$clog2(NEW_FEATURE_DEPTH)-1:0] feat_addr,
    input  logic [NEW_FEATURE_WIDTH-1:0]         feat_dout,
    output logic                                 m_valid,
    output logic [NEW_FEATURE_WIDTH-1:0]         m_data,
    output logic                                 m_last,
    input  logic                                 m_ready,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error
);

    localparam int AW  = $clog2(NEW_FEATURE_DEPTH);
    localparam int LW  = $clog2(NUM_LAYERS + 1);
    localparam int FD  = RD_LAT + 1;
    localparam int FCW = $clog2(FD + 1);
    localparam int CRW = FCW + 1;

    gat_state_e            state_r;
    gat_state_e            next_state_s;
    logic [LW-1:0]         layer_r;
    logic                  all_loaded_s;
    logic                  more_layers_s;
    logic                  timeout_s;

    logic                  core_start_s, load_req_s, busy_s, done_s;
    logic                  core_start_r, load_req_r, busy_r, done_r;

    logic [AW-1:0]         feat_addr_r;
    logic                  rd_all_r;
    logic                  last_addr_s;
    logic                  issue_s;
    logic [FCW-1:0]        outstanding_r;
    logic [RD_LAT-1:0]     vld_pipe_r;
    logic [RD_LAT-1:0]     last_pipe_r;
    logic [CRW-1:0]        credit_s;

    logic                  fifo_wr_s;
    logic [NEW_FEATURE_WIDTH:0] fifo_rd_data_s;
    logic [FCW-1:0]        fifo_count_s;
    logic                  fifo_empty_s;
    logic                  fifo_last_s;
    logic                  m_valid_s;
    logic                  pop_s;

    assign all_loaded_s  = h_data_load_done && h_node_info_load_done && wgt_load_done;
    assign more_layers_s = (layer_r + LW'(1)) < LW'(NUM_LAYERS);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; the watchdog takes priority over normal progress.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = WAIT_LOAD;
                else       next_state_s = IDLE;
            end
            WAIT_LOAD: begin
                if (timeout_s)         next_state_s = IDLE;
                else if (all_loaded_s) next_state_s = KICK;
                else                   next_state_s = WAIT_LOAD;
            end
            KICK: begin
                next_state_s = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (timeout_s)       next_state_s = IDLE;
                else if (!gat_ready) next_state_s = WAIT_DONE;
                else                 next_state_s = WAIT_ACK;
            end
            WAIT_DONE: begin
                if (timeout_s) begin
                    next_state_s = IDLE;
                end else if (gat_ready) begin
                    if (more_layers_s) next_state_s = WAIT_LOAD;
                    else               next_state_s = READBACK;
                end else begin
                    next_state_s = WAIT_DONE;
                end
            end
            READBACK: begin
                if (pop_s && fifo_last_s) next_state_s = FINISH;
                else                      next_state_s = READBACK;
            end
            FINISH: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered copies track state_r exactly.
    always_comb begin
        core_start_s = 1'b0;
        load_req_s   = 1'b0;
        done_s       = 1'b0;
        busy_s       = 1'b1;
        case (next_state_s)
            IDLE:      busy_s       = 1'b0;
            WAIT_LOAD: load_req_s   = 1'b1;
            KICK:      core_start_s = 1'b1;
            FINISH:    done_s       = 1'b1;
            default:   busy_s       = 1'b1;
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_start_r <= 1'b0;
            load_req_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            core_start_r <= core_start_s;
            load_req_r   <= load_req_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    // Layer counter: cleared on an accepted start, advanced when the core finishes a layer.
    always_ff @(posedge clk) begin
        if (rst) begin
            layer_r <= {LW{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            layer_r <= {LW{1'b0}};
        end else if ((state_r == WAIT_DONE) && gat_ready && !timeout_s) begin
            layer_r <= layer_r + LW'(1);
        end
    end

    // Issue credit counts the head word as already gone when it pops this cycle,
    // which is what lets the stream run at one word per clock.
    assign pop_s       = m_valid_s && m_ready;
    assign credit_s    = CRW'(outstanding_r) + CRW'(fifo_count_s) - CRW'(pop_s);
    assign last_addr_s = (feat_addr_r == AW'(NEW_FEATURE_DEPTH - 1));
    assign issue_s     = (state_r == READBACK) && !rd_all_r && (credit_s < CRW'(FD));
    assign fifo_wr_s   = vld_pipe_r[RD_LAT-1];

    // Read address generator; parked at zero outside readback.
    always_ff @(posedge clk) begin
        if (rst || (state_r != READBACK)) begin
            feat_addr_r <= {AW{1'b0}};
            rd_all_r    <= 1'b0;
        end else if (issue_s) begin
            if (last_addr_s) begin
                rd_all_r <= 1'b1;
            end else begin
                feat_addr_r <= feat_addr_r + AW'(1);
            end
        end
    end

    // BRAM latency tracker and in-flight read count.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_r    <= {RD_LAT{1'b0}};
            last_pipe_r   <= {RD_LAT{1'b0}};
            outstanding_r <= {FCW{1'b0}};
        end else begin
            vld_pipe_r[0]  <= issue_s;
            last_pipe_r[0] <= issue_s && last_addr_s;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                last_pipe_r[i] <= last_pipe_r[i-1];
            end
            outstanding_r <= outstanding_r + FCW'(issue_s) - FCW'(fifo_wr_s);
        end
    end

    gat_rd_fifo #(
        .DEPTH (FD),
        .WIDTH (NEW_FEATURE_WIDTH + 1)
    ) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr_s),
        .wr_data ({last_pipe_r[RD_LAT-1], feat_dout}),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .count   (fifo_count_s),
        .empty   (fifo_empty_s)
    );

    assign m_valid_s   = !fifo_empty_s;
    assign fifo_last_s = fifo_rd_data_s[NEW_FEATURE_WIDTH];

`ifdef GAT_SCHED_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] phase_cnt_r;
    logic           in_phase_s;
    logic           error_r;

    assign in_phase_s = (state_r == WAIT_LOAD) || (state_r == WAIT_ACK) || (state_r == WAIT_DONE);
    assign timeout_s  = in_phase_s && (phase_cnt_r == TCW'(TIMEOUT_CYCLES - 1));

    // Per-phase cycle counter, restarted on every state change.
    always_ff @(posedge clk) begin
        if (rst || (next_state_s != state_r) || !in_phase_s) begin
            phase_cnt_r <= {TCW{1'b0}};
        end else begin
            phase_cnt_r <= phase_cnt_r + TCW'(1);
        end
    end

    // Sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_r <= 1'b0;
        end else if (timeout_s) begin
            error_r <= 1'b1;
        end
    end

    assign error = error_r;
`else
    // Watchdog compiled out: phases wait forever and the limit parameter is inert.
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
    assign timeout_s        = 1'b0;
    assign error            = 1'b0;
`endif

    assign gat_layer  = layer_r[0];
    assign core_start = core_start_r;
    assign load_req   = load_req_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign feat_addr  = feat_addr_r;
    assign m_valid    = m_valid_s;
    assign m_data     = m_valid_s ? fifo_rd_data_s[NEW_FEATURE_WIDTH-1:0] : {NEW_FEATURE_WIDTH{1'b0}};
    assign m_last     = m_valid_s && fifo_last_s;

endmodule

// File: tb/tb_gat_layer_scheduler.sv
// Directed bench for gat_layer_scheduler: two-layer runs, handshake timing, full-rate and
// stalled readback, mid-readback reset, and the watchdog when GAT_SCHED_TIMEOUT_EN is defined.
module tb_gat_layer_scheduler;
    import gat_pkg::*;

    localparam int DEPTH = 8;
    localparam int W     = 32;
    localparam int LAT   = 2;

    logic           clk = 1'b0;
    logic           rst, start, h_data_load_done, h_node_info_load_done, wgt_load_done;
    logic           gat_ready, gat_layer, core_start, load_req;
    logic [2:0]     feat_addr;
    logic [W-1:0]   feat_dout;
    logic           m_valid, m_last, m_ready, busy, done, error;
    logic [W-1:0]   m_data;

    logic [W-1:0]   bram_p1, bram_p2;
    int             n_checks = 0;
    int             n_errors = 0;
    int             cs_cnt = 0;
    int             done_cnt = 0;
    int             cs_base, done_base;

    always #5 clk = ~clk;

    gat_layer_scheduler #(
        .NUM_LAYERS        (2),
        .NEW_FEATURE_DEPTH (DEPTH),
        .NEW_FEATURE_WIDTH (W),
        .RD_LAT            (LAT),
        .TIMEOUT_CYCLES    (100)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .h_data_load_done      (h_data_load_done),
        .h_node_info_load_done (h_node_info_load_done),
        .wgt_load_done         (wgt_load_done),
        .gat_ready             (gat_ready),
        .gat_layer             (gat_layer),
        .core_start            (core_start),
        .load_req              (load_req),
        .feat_addr             (feat_addr),
        .feat_dout             (feat_dout),
        .m_valid               (m_valid),
        .m_data                (m_data),
        .m_last                (m_last),
        .m_ready               (m_ready),
        .busy                  (busy),
        .done                  (done),
        .error                 (error)
    );

    function automatic logic [W-1:0] word_at(input int a);
        return 32'hC0DE_0000 + 32'(a);
    endfunction

    // Two-cycle-latency feature BRAM model.
    always @(posedge clk) begin
        bram_p1 <= word_at(int'(feat_addr));
        bram_p2 <= bram_p1;
    end
    assign feat_dout = bram_p2;

    // Pulse counters for core_start and done.
    always @(negedge clk) begin
        if (core_start === 1'b1) cs_cnt <= cs_cnt + 1;
        if (done === 1'b1)       done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ":gat_layer"},  gat_layer,  0);
        chk({tag, ":core_start"}, core_start, 0);
        chk({tag, ":load_req"},   load_req,   0);
        chk({tag, ":feat_addr"},  feat_addr,  0);
        chk({tag, ":m_valid"},    m_valid,    0);
        chk({tag, ":m_data"},     m_data,     0);
        chk({tag, ":m_last"},     m_last,     0);
        chk({tag, ":busy"},       busy,       0);
        chk({tag, ":done"},       done,       0);
        chk({tag, ":error"},      error,      0);
    endtask

    task automatic start_run(input string tag);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, ":load_req"}, load_req, 1);
    endtask

    task automatic wait_kick(input string tag, input logic exp_layer);
        int n = 0;
        while (core_start !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk({tag, ":kick_seen"},  core_start, 1);
        chk({tag, ":kick_layer"}, gat_layer,  exp_layer);
    endtask

    // Called at the KICK sample: ready stays high for hi cycles, then low for lo cycles.
    task automatic run_layer(input string tag, input int hi, input int lo, input logic exp_layer);
        int  n_ack = 0;
        int  n_done = 0;
        logic bad = 1'b0;
        for (int i = 0; i < hi; i++) begin
            tick;
            if (dut.state_r == WAIT_ACK) n_ack++;
            if (gat_layer !== exp_layer || core_start !== 1'b0) bad = 1'b1;
        end
        gat_ready = 1'b0;
        start     = 1'b1;
        for (int i = 0; i < lo; i++) begin
            tick;
            start = 1'b0;
            if (dut.state_r == WAIT_DONE) n_done++;
            if (gat_layer !== exp_layer || core_start !== 1'b0) bad = 1'b1;
        end
        gat_ready = 1'b1;
        chk({tag, ":wait_ack_cycles"},  n_ack,  hi);
        chk({tag, ":wait_done_cycles"}, n_done, lo);
        chk({tag, ":layer_stable"},     bad,    0);
    endtask

    task automatic readback(input string tag, input int abort_after);
        int n = 0;
        while (m_valid !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        for (int k = 0; k < DEPTH; k++) begin
            chk({tag, ":m_valid"}, m_valid, 1);
            chk({tag, ":m_data"},  m_data,  word_at(k));
            chk({tag, ":m_last"},  m_last,  (k == DEPTH - 1));
            tick;
            if (k == abort_after - 1) begin
                rst = 1'b1;
                tick;
                rst = 1'b0;
                check_idle({tag, ":abort"});
                return;
            end
        end
        chk({tag, ":done_pulse"}, done, 1);
        chk({tag, ":busy_finish"}, busy, 1);
        tick;
        chk({tag, ":done_clear"}, done, 0);
        chk({tag, ":busy_idle"}, busy, 0);
        chk({tag, ":valid_idle"}, m_valid, 0);
    endtask

    task automatic readback_rand(input string tag);
        int           k = 0;
        int           n = 0;
        logic         stalled = 1'b0;
        logic [W-1:0] held = '0;
        while (k < DEPTH && n < 400) begin
            tick;
            n++;
            if (stalled) begin
                chk({tag, ":hold_valid"}, m_valid, 1);
                chk({tag, ":hold_data"},  m_data,  held);
            end
            m_ready = 1'($urandom_range(0, 1));
            if (m_valid === 1'b1 && m_ready) begin
                chk({tag, ":m_data"}, m_data, word_at(k));
                chk({tag, ":m_last"}, m_last, (k == DEPTH - 1));
                k++;
            end
            stalled = (m_valid === 1'b1) && !m_ready;
            held    = m_data;
        end
        m_ready = 1'b1;
        chk({tag, ":word_count"}, k, DEPTH);
        tick;
        chk({tag, ":done_pulse"}, done, 1);
        chk({tag, ":no_extra"},   m_valid, 0);
        tick;
        chk({tag, ":busy_idle"},  busy, 0);
    endtask

    task automatic two_layers(input string tag, input int hi0, input int lo0, input int hi1, input int lo1);
        wait_kick({tag, "_l0"}, 1'b0);
        run_layer({tag, "_l0"}, hi0, lo0, 1'b0);
        wait_kick({tag, "_l1"}, 1'b1);
        run_layer({tag, "_l1"}, hi1, lo1, 1'b1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; gat_ready = 1'b1; m_ready = 1'b1;
        h_data_load_done = 1'b0; h_node_info_load_done = 1'b0; wgt_load_done = 1'b0;
        repeat (3) tick;
        check_idle("reset");
        rst = 1'b0;
        tick;

        // Run 1: loads complete at WAIT_LOAD cycle 5, slow core ack on layer 0.
        cs_base = cs_cnt; done_base = done_cnt;
        start_run("run1");
        for (int i = 2; i <= 5; i++) begin
            tick;
            chk("run1:wait_load", {load_req, core_start}, 2'b10);
            if (i == 3) begin
                h_data_load_done      = 1'b1;
                h_node_info_load_done = 1'b1;
            end
        end
        wgt_load_done = 1'b1;
        two_layers("run1", 3, 10, 1, 4);
        readback("run1_rb", -1);
        chk("run1:core_start_pulses", cs_cnt - cs_base, 2);
        chk("run1:done_pulses", done_cnt - done_base, 1);

        // Run 2: random backpressure on the result stream.
        cs_base = cs_cnt; done_base = done_cnt;
        start_run("run2");
        two_layers("run2", 2, 5, 1, 2);
        readback_rand("run2_rb");
        chk("run2:core_start_pulses", cs_cnt - cs_base, 2);
        chk("run2:done_pulses", done_cnt - done_base, 1);

        // Run 3: reset after the third readback word, then a clean rerun.
        start_run("run3");
        two_layers("run3", 1, 3, 1, 3);
        readback("run3_rb", 3);
        cs_base = cs_cnt; done_base = done_cnt;
        start_run("run4");
        two_layers("run4", 1, 2, 2, 2);
        readback("run4_rb", -1);
        chk("run4:core_start_pulses", cs_cnt - cs_base, 2);
        chk("run4:done_pulses", done_cnt - done_base, 1);

`ifdef GAT_SCHED_TIMEOUT_EN
        begin
            int n = 0;
            wgt_load_done = 1'b0;
            done_base = done_cnt;
            start_run("tmo");
            for (int i = 0; i < 200 && error !== 1'b1; i++) begin
                if (load_req === 1'b1) n++;
                tick;
            end
            chk("tmo:wait_load_cycles", n, 100);
            chk("tmo:error", error, 1);
            chk("tmo:idle", {busy, load_req}, 2'b00);
            tick;
            chk("tmo:error_sticky", error, 1);
            chk("tmo:no_done", done_cnt - done_base, 0);
            rst = 1'b1;
            tick;
            rst = 1'b0;
            check_idle("tmo_reset");
        end
`else
        chk("error_tied_low", error, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/gat_layer_scheduler.md
GAT_LAYER_SCHEDULER -- requirements
Module: gat_layer_scheduler

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 2, number of GAT layers run per start.
REQ-002 SHALL have parameter NEW_FEATURE_DEPTH, default 43328, number of feature words read back after the final layer.
REQ-003 SHALL have parameter NEW_FEATURE_WIDTH, default 32, width of a feature word.
REQ-004 SHALL have parameter RD_LAT, default 2, feature BRAM read latency in cycles.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 2^24, watchdog limit per phase.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle run request; accepted only in IDLE.
- h_data_load_done  in  1  host load flag.
- h_node_info_load_done  in  1  host load flag.
- wgt_load_done  in  1  host load flag.
- gat_ready  in  1  core idle level.
- gat_layer  out  1  current layer index to the core.
- core_start  out  1  one-cycle kick to the core.
- load_req  out  1  level; asks the host to load the next layer's weights.
- feat_addr  out  $clog2(NEW_FEATURE_DEPTH)  feature BRAM read word address.
- feat_dout  in  NEW_FEATURE_WIDTH  feature BRAM read data.
- m_valid, m_data[NEW_FEATURE_WIDTH], m_last  out  result stream.
- m_ready  in  1  result stream ready.
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse at end of run.
- error  out  1  sticky watchdog flag.

Function
REQ-007 FSM states SHALL be IDLE, WAIT_LOAD, KICK, WAIT_ACK, WAIT_DONE, READBACK, FINISH.
REQ-008 IDLE->WAIT_LOAD SHALL occur on start; layer counter SHALL clear to 0.
REQ-009 In WAIT_LOAD, load_req SHALL be 1; the FSM SHALL go to KICK when all three load_done flags are 1 in the same cycle.
REQ-010 KICK SHALL last exactly one cycle with core_start=1; gat_layer SHALL equal the layer counter and be stable from KICK through WAIT_DONE.
REQ-011 WAIT_ACK SHALL exit to WAIT_DONE on the first cycle gat_ready=0; WAIT_DONE SHALL exit on the first cycle gat_ready=1.
REQ-012 On WAIT_DONE exit the counter SHALL increment. If counter+1<NUM_LAYERS the FSM SHALL go to WAIT_LOAD; otherwise it SHALL go to READBACK.
REQ-013 READBACK SHALL read addresses 0..NEW_FEATURE_DEPTH-1 in order, through an internal FIFO of depth RD_LAT+1.
REQ-014 A read SHALL be issued only while outstanding reads plus FIFO occupancy is less than RD_LAT+1; data SHALL be written to the FIFO RD_LAT cycles after issue.
REQ-015 m_valid=1 SHALL mean the FIFO is not empty; a word SHALL pop when m_valid&&m_ready; m_data SHALL hold while m_valid&&!m_ready.
REQ-016 m_last SHALL be 1 only with the word from address NEW_FEATURE_DEPTH-1; its pop SHALL move the FSM to FINISH.
REQ-017 With m_ready=1 continuously, the scheduler SHALL sustain one word per cycle after the first RD_LAT+1 cycles.
REQ-018 FINISH SHALL assert done for one cycle and return to IDLE.
REQ-019 start outside IDLE SHALL be ignored; load flags changing outside WAIT_LOAD SHALL be ignored.

Reset
REQ-020 rst=1 on any clock edge SHALL force IDLE from any state, including mid-READBACK, and SHALL flush the FIFO and outstanding-read counter.
REQ-021 Reset values SHALL be: gat_layer=0, core_start=0, load_req=0, feat_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, error=0.

Configuration
REQ-022 Macro GAT_SCHED_TIMEOUT_EN defined: a per-phase counter SHALL run in WAIT_LOAD, WAIT_ACK and WAIT_DONE and SHALL clear on every state change.
- Reaching TIMEOUT_CYCLES SHALL set error=1 (sticky until rst) and go to IDLE without pulsing done.
REQ-023 Macro GAT_SCHED_TIMEOUT_EN undefined: error SHALL be tied to 0, the counter logic SHALL be absent, and the phases SHALL wait indefinitely.

Structure
REQ-024 Package gat_pkg SHALL hold the state enum and the default NEW_FEATURE_DEPTH/WIDTH constants.
REQ-025 The readback FIFO SHALL be sub-module gat_rd_fifo (parameterised depth and width, synchronous active-high reset).

Verification
REQ-026 Bench SHALL cover, with NUM_LAYERS=2 and all load flags set at cycle 5: core_start pulses twice, with gat_layer=0 then 1, and done follows readback.
REQ-027 Bench SHALL cover gat_ready held 1 for 3 cycles after KICK, then 0 for 10, then 1: the FSM stays in WAIT_ACK for 3 cycles and the layer completes after the 10-cycle low.
REQ-028 Bench SHALL cover NEW_FEATURE_DEPTH=8 with m_ready=1: words from addresses 0..7 appear on 8 consecutive cycles, with m_last on the 8th.
REQ-029 Bench SHALL cover m_ready toggled randomly: no words lost or duplicated, and m_data holds while stalled.
REQ-030 Bench SHALL cover rst asserted after the 3rd readback word: all outputs return to reset values the next cycle, and a new start runs cleanly.
REQ-031 Bench SHALL cover GAT_SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=100 and wgt_load_done never set: error=1 at cycle 100 of WAIT_LOAD, FSM in IDLE, and no done pulse.
